// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares the single block-wide backing memory port between two cache
//   requesters (port 0 = I-side, port 1 = D-side). One block read (refill)
//   or block write (writeback) is in flight at a time. Each operation runs
//   IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP, so a grant is followed
//   by a one-cycle done pulse MEM_LAT+2 cycles later for reads and writes
//   alike. Every output is a flop.
//
//   Optional build macro: ARB_FIXED_PRIO_EN
//     undefined - simultaneous requests are granted round-robin
//     defined   - port 0 always wins simultaneous requests
//
//   Ports
//     clk, rst               clock, synchronous active-high reset
//     req/we/addr/wr_blk 0,1 requester side; req held until done is seen
//     done0, done1           one-cycle completion pulse per requester
//     rd_blk                 captured read block, valid with done0/done1
//     busy                   high whenever the arbiter is not IDLE
//     mem_addr, mem_rd_en,
//     mem_wr_en, mem_wr_blk  memory request, enables high only in ISSUE
//     mem_rd_blk             memory read data, MEM_LAT cycles after enable
module cache_mem_arbiter #(
  parameter int PA_WIDTH  = 32,
  parameter int BLK_WIDTH = 512,
  parameter int MEM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [PA_WIDTH-1:0]  addr0,
  input  logic [BLK_WIDTH-1:0] wr_blk0,
  output logic                 done0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [PA_WIDTH-1:0]  addr1,
  input  logic [BLK_WIDTH-1:0] wr_blk1,
  output logic                 done1,
  output logic [BLK_WIDTH-1:0] rd_blk,
  output logic                 busy,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BLK_WIDTH-1:0] mem_wr_blk,
  input  logic [BLK_WIDTH-1:0] mem_rd_blk
);

  // Byte offset bits inside a block; the memory is addressed per block.
  localparam logic [PA_WIDTH-1:0] OFFSET_MASK = PA_WIDTH'(BLK_WIDTH / 8 - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic                 gnt, gnt_nxt;
  logic                 op_we, op_we_nxt;
  logic                 win;
  logic                 done0_nxt, done1_nxt, busy_nxt;
  logic                 mem_rd_en_nxt, mem_wr_en_nxt;
  logic [PA_WIDTH-1:0]  mem_addr_nxt;
  logic [BLK_WIDTH-1:0] mem_wr_blk_nxt, rd_blk_nxt;
`ifndef ARB_FIXED_PRIO_EN
  logic                 last_gnt, last_gnt_nxt;
`endif

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // and registered below, so the memory enables appear exactly during ISSUE
  // and the done pulse exactly during RESP. The request payload is latched
  // straight into the mem_addr/mem_wr_blk registers at grant, which keeps
  // them stable through WAIT whatever the requester does afterwards.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    gnt_nxt        = gnt;
    op_we_nxt      = op_we;
    win            = 1'b0;
    done0_nxt      = 1'b0;
    done1_nxt      = 1'b0;
    mem_rd_en_nxt  = 1'b0;
    mem_wr_en_nxt  = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_wr_blk_nxt = mem_wr_blk;
    rd_blk_nxt     = rd_blk;
`ifndef ARB_FIXED_PRIO_EN
    last_gnt_nxt   = last_gnt;
`endif

    case (state)
      IDLE: begin
        if (req0 || req1) begin
`ifdef ARB_FIXED_PRIO_EN
          win = !req0;
`else
          // With both requesting, the port not served last wins. Every
          // grant is remembered so service alternates under contention.
          win          = (req0 && req1) ? !last_gnt : req1;
          last_gnt_nxt = win;
`endif
          gnt_nxt        = win;
          op_we_nxt      = win ? we1 : we0;
          mem_addr_nxt   = (win ? addr1 : addr0) & ~OFFSET_MASK;
          mem_wr_blk_nxt = win ? wr_blk1 : wr_blk0;
          mem_rd_en_nxt  = !(win ? we1 : we0);
          mem_wr_en_nxt  = win ? we1 : we0;
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = 4'(MEM_LAT - 1);
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          // Memory data is valid on this edge only; writes keep rd_blk.
          if (!op_we) begin
            rd_blk_nxt = mem_rd_blk;
          end
          done0_nxt = !gnt;
          done1_nxt = gnt;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers. Reset abandons any in-flight access and
  // clears every output; the round-robin pointer favours port 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt        <= 1'b0;
      op_we      <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_wr_blk <= '0;
      rd_blk     <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_gnt   <= 1'b1;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      gnt        <= gnt_nxt;
      op_we      <= op_we_nxt;
      done0      <= done0_nxt;
      done1      <= done1_nxt;
      busy       <= busy_nxt;
      mem_rd_en  <= mem_rd_en_nxt;
      mem_wr_en  <= mem_wr_en_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wr_blk <= mem_wr_blk_nxt;
      rd_blk     <= rd_blk_nxt;
`ifndef ARB_FIXED_PRIO_EN
      last_gnt   <= last_gnt_nxt;
`endif
    end
  end

endmodule
